// File: rtl/alu.sv
// Four-op unsigned ALU: single-cycle ADD/SUB/MUL and a bit-serial restoring divider.
// Every result is registered, flagged, and marked by a one-cycle out_valid pulse.
//
// state  | meaning
// S_IDLE | accepting requests, 1-cycle ops complete here
// S_DIV  | divider iterating, one quotient bit per cycle
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] rem,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   quo_sh;
  logic [WIDTH-1:0]   step_r;
  logic [WIDTH-1:0]   step_q;
  logic [WIDTH:0]     trial;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = a - b;
    prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // Restoring step: shift next dividend bit into the partial remainder, try subtract.
    rem_sh = {pr_q, quo_q[WIDTH-1]};
    quo_sh = quo_q << 1;
    trial  = rem_sh - {1'b0, dvs_q};
    if (rem_sh >= {1'b0, dvs_q}) begin
      step_r = trial[WIDTH-1:0];
      step_q = quo_sh | {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      step_r = rem_sh[WIDTH-1:0];
      step_q = quo_sh;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvs_d       = dvs_q;
    pr_d        = pr_q;
    quo_d       = quo_q;
    f_d         = f_q;
    rem_d       = rem_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (op)
            OP_ADD: begin
              f_d         = sum[WIDTH-1:0];
              rem_d       = '0;
              carry_d     = sum[WIDTH];
              ovf_d       = 1'b0;
              dz_d        = 1'b0;
              out_valid_d = 1'b1;
            end
            OP_SUB: begin
              f_d         = diff;
              rem_d       = '0;
              carry_d     = (a < b);
              ovf_d       = 1'b0;
              dz_d        = 1'b0;
              out_valid_d = 1'b1;
            end
            OP_MUL: begin
              f_d         = prod[WIDTH-1:0];
              rem_d       = '0;
              carry_d     = 1'b0;
              ovf_d       = |prod[2*WIDTH-1:WIDTH];
              dz_d        = 1'b0;
              out_valid_d = 1'b1;
            end
            OP_DIV: begin
              if (b == '0) begin
                f_d         = '1;
                rem_d       = a;
                carry_d     = 1'b0;
                ovf_d       = 1'b0;
                dz_d        = 1'b1;
                out_valid_d = 1'b1;
              end else begin
                dvs_d   = b;
                quo_d   = a;
                pr_d    = '0;
                cnt_d   = CW'(WIDTH - 1);
                state_d = S_DIV;
              end
            end
            default: ;
          endcase
        end
      end
      S_DIV: begin
        pr_d  = step_r;
        quo_d = step_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          f_d         = step_q;
          rem_d       = step_r;
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          dz_d        = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    zero_d = (f_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      quo_q       <= '0;
      f_q         <= '0;
      rem_q       <= '0;
      zero_q      <= 1'b1;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvs_q       <= dvs_d;
      pr_q        <= pr_d;
      quo_q       <= quo_d;
      f_q         <= f_d;
      rem_q       <= rem_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (state_q == S_DIV);
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign rem       = rem_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, reset abort, then random ops
// compared against an arithmetic reference model.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic [1:0] op;
  logic       in_valid;
  logic       busy, out_valid, zero, carry, ovf, dz;
  logic [7:0] f, rem;

  int n_checks = 0;
  int n_errors = 0;

  alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .in_valid(in_valid),
    .busy(busy), .out_valid(out_valid), .f(f), .rem(rem),
    .zero(zero), .carry(carry), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int op_m, input int a_m, input int b_m,
                                output int ef, output int er, output int ec,
                                output int eo, output int ed);
    int p;
    ef = 0; er = 0; ec = 0; eo = 0; ed = 0;
    case (op_m)
      0: begin p = a_m + b_m; ef = p % 256; ec = (p >= 256); end
      1: begin ef = (a_m - b_m + 256) % 256; ec = (a_m < b_m); end
      2: begin p = a_m * b_m; ef = p % 256; eo = (p >= 256); end
      default: begin
        if (b_m == 0) begin ef = 255; er = a_m; ed = 1; end
        else begin ef = a_m / b_m; er = a_m % b_m; end
      end
    endcase
  endfunction

  task automatic check_result(input int ef, input int er, input int ec, input int eo, input int ed);
    check("f", f, ef);
    check("rem", rem, er);
    check("zero", zero, (ef == 0));
    check("carry", carry, ec);
    check("ovf", ovf, eo);
    check("dz", dz, ed);
  endtask

  task automatic run_op(input logic [1:0] op_t, input logic [7:0] a_t, input logic [7:0] b_t,
                        input bit hold_chk);
    int ef, er, ec, eo, ed, lat, bcnt;
    bit slow;
    model(int'(op_t), int'(a_t), int'(b_t), ef, er, ec, eo, ed);
    slow = (op_t == 2'b11) && (b_t != 0);
    @(negedge clk);
    a = a_t; b = b_t; op = op_t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 30) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, slow ? 9 : 1);
    check("busy_cycles", bcnt, slow ? 8 : 0);
    check("out_valid", out_valid, 1);
    check("busy_at_result", busy, 0);
    check_result(ef, er, ec, eo, ed);
    if (hold_chk) begin
      @(posedge clk); #1;
      check("out_valid_pulse", out_valid, 0);
      check("f_hold", f, ef);
      check("rem_hold", rem, er);
    end
  endtask

  task automatic check_reset_state();
    check("rst_f", f, 0);
    check("rst_rem", rem, 0);
    check("rst_zero", zero, 1);
    check("rst_carry", carry, 0);
    check("rst_ovf", ovf, 0);
    check("rst_dz", dz, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
  endtask

  initial begin
    int nv, lat;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;

    // Directed examples
    run_op(2'b00, 8'd15, 8'd10, 1'b1);
    run_op(2'b01, 8'd25, 8'd5, 1'b1);
    run_op(2'b01, 8'd5, 8'd25, 1'b1);
    run_op(2'b10, 8'd3, 8'd4, 1'b1);
    run_op(2'b10, 8'd16, 8'd16, 1'b1);
    run_op(2'b11, 8'd20, 8'd4, 1'b1);
    run_op(2'b11, 8'd20, 8'd0, 1'b1);
    run_op(2'b00, 8'd255, 8'd1, 1'b1);
    run_op(2'b11, 8'd0, 8'd9, 1'b1);
    run_op(2'b11, 8'd255, 8'd1, 1'b1);
    run_op(2'b11, 8'd3, 8'd200, 1'b1);

    // Divide with ignored request while busy, then reset aborts it
    @(negedge clk);
    a = 8'd200; b = 8'd7; op = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("div_busy", busy, 1);
    @(negedge clk);
    a = 8'd1; b = 8'd1; op = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ignored_add_busy", busy, 1);
    check("ignored_add_ov", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state();
    nv = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) nv++;
    end
    check("aborted_out_valid", nv, 0);
    check("aborted_busy", busy, 0);

    // Same divide without reset
    @(negedge clk);
    a = 8'd200; b = 8'd7; op = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    a = 8'd1; b = 8'd1; op = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'd0; b = 8'd0; op = 2'b01;
    lat = 2;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("div200_latency", lat, 9);
    check_result(28, 4, 0, 0, 0);
    @(posedge clk); #1;
    check("div200_no_extra", out_valid, 0);

    // Back-to-back single-cycle ops, one per clock
    for (int i = 0; i < 12; i++) begin
      int ef, er, ec, eo, ed;
      logic [1:0] op_r;
      logic [7:0] a_r, b_r;
      op_r = 2'($urandom_range(0, 3));
      a_r  = 8'($urandom);
      b_r  = (op_r == 2'b11) ? 8'd0 : 8'($urandom);
      model(int'(op_r), int'(a_r), int'(b_r), ef, er, ec, eo, ed);
      @(negedge clk);
      a = a_r; b = b_r; op = op_r; in_valid = 1'b1;
      @(posedge clk); #1;
      check("b2b_out_valid", out_valid, 1);
      check("b2b_busy", busy, 0);
      check_result(ef, er, ec, eo, ed);
    end
    @(negedge clk);
    in_valid = 1'b0;

    // Random mix; without the hold check the next request lands in the result cycle
    for (int i = 0; i < 150; i++) begin
      logic [1:0] op_r;
      logic [7:0] a_r, b_r;
      op_r = 2'($urandom_range(0, 3));
      a_r  = 8'($urandom);
      b_r  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      run_op(op_r, a_r, b_r, bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
